// File: rtl/apb_pkg.sv
// Shared types and default bus widths for the APB master arbiter.
package apb_pkg;

    typedef enum logic [1:0] {
        APB_IDLE,
        APB_SETUP,
        APB_ACCESS
    } apb_state_t;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first unmasked request at or after
// the pointer wins, wrapping around to index 0.
module rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic [NUM_REQ-1:0]         i_mask,
    input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
    output logic [NUM_REQ-1:0]         o_win
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] w_active;
    logic [PTR_W-1:0]   w_hi_idx;
    logic [PTR_W-1:0]   w_lo_idx;
    logic               w_hi_vld;
    logic               w_lo_vld;

    assign w_active = i_req & ~i_mask;

    // Descending scan so the lowest index in each half is the one kept.
    always_comb begin
        w_hi_vld = 1'b0;
        w_lo_vld = 1'b0;
        w_hi_idx = '0;
        w_lo_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_active[i]) begin
                if (i >= int'(i_ptr)) begin
                    w_hi_vld = 1'b1;
                    w_hi_idx = PTR_W'(i);
                end else begin
                    w_lo_vld = 1'b1;
                    w_lo_idx = PTR_W'(i);
                end
            end
        end
    end

    always_comb begin
        o_win = '0;
        if (w_hi_vld) begin
            o_win[w_hi_idx] = 1'b1;
        end else if (w_lo_vld) begin
            o_win[w_lo_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// APB master sharing one bus between NUM_REQ requesters: round-robin grant,
// back-to-back SETUP after a completed transfer, optional wait-state timeout.
module apb_master_arbiter
    import apb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic                      PCLK,
    input  logic                      PRESET,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ-1:0]        write_i,
    input  logic [NUM_REQ*ADDR_W-1:0] addr_i,
    input  logic [NUM_REQ*DATA_W-1:0] wdata_i,
    output logic [NUM_REQ-1:0]        gnt_o,
    output logic [NUM_REQ-1:0]        done_o,
    output logic                      err_o,
    output logic [DATA_W-1:0]         rdata_o,
    output logic                      PSEL,
    output logic                      PENABLE,
    output logic                      PWRITE,
    output logic [ADDR_W-1:0]         PADDR,
    output logic [DATA_W-1:0]         PWDATA,
    input  logic [DATA_W-1:0]         PRDATA,
    input  logic                      PREADY
);

    localparam int PTR_W  = $clog2(NUM_REQ);
    localparam int WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit TIMEOUT_EN = (TIMEOUT != 0);
    localparam logic [WAIT_W-1:0] WAIT_LAST = (TIMEOUT > 0) ? WAIT_W'(TIMEOUT - 1) : '0;
    localparam logic [WAIT_W-1:0] WAIT_MAX  = '1;

    apb_state_t          r_state;
    logic                r_psel;
    logic                r_penable;
    logic                r_pwrite;
    logic [ADDR_W-1:0]   r_paddr;
    logic [DATA_W-1:0]   r_pwdata;
    logic [NUM_REQ-1:0]  r_gnt;
    logic [PTR_W-1:0]    r_gnt_idx;
    logic [PTR_W-1:0]    r_ptr;
    logic [WAIT_W-1:0]   r_wait;

    logic                w_in_access;
    logic                w_complete;
    logic                w_timeout;
    logic                w_done;
    logic [PTR_W-1:0]    w_ptr_adv;
    logic [PTR_W-1:0]    w_arb_ptr;
    logic [NUM_REQ-1:0]  w_arb_mask;
    logic [NUM_REQ-1:0]  w_win;
    logic                w_win_any;
    logic [PTR_W-1:0]    w_win_idx;
    logic                w_win_write;
    logic [ADDR_W-1:0]   w_win_addr;
    logic [DATA_W-1:0]   w_win_wdata;

    assign w_in_access = (r_state == APB_ACCESS);
    assign w_complete  = w_in_access && PREADY;
    assign w_timeout   = TIMEOUT_EN && w_in_access && !PREADY && (r_wait == WAIT_LAST);
    assign w_done      = w_complete || w_timeout;
    assign w_ptr_adv   = (r_gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : r_gnt_idx + 1'b1;

    // In the completion cycle the grantee is masked and priority already
    // starts after it, so a back-to-back pick sees the advanced pointer.
    assign w_arb_ptr  = w_done ? w_ptr_adv : r_ptr;
    assign w_arb_mask = w_in_access ? r_gnt : '0;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .i_req  (req_i),
        .i_mask (w_arb_mask),
        .i_ptr  (w_arb_ptr),
        .o_win  (w_win)
    );

    assign w_win_any = |w_win;

    always_comb begin
        w_win_idx   = '0;
        w_win_write = 1'b0;
        w_win_addr  = '0;
        w_win_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win[i]) begin
                w_win_idx   = PTR_W'(i);
                w_win_write = write_i[i];
                w_win_addr  = addr_i[i*ADDR_W +: ADDR_W];
                w_win_wdata = wdata_i[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state   <= APB_IDLE;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= '0;
            r_pwdata  <= '0;
            r_gnt     <= '0;
            r_gnt_idx <= '0;
            r_ptr     <= '0;
            r_wait    <= '0;
        end else begin
            case (r_state)
                APB_IDLE: begin
                    if (w_win_any) begin
                        r_state   <= APB_SETUP;
                        r_psel    <= 1'b1;
                        r_penable <= 1'b0;
                        r_gnt     <= w_win;
                        r_gnt_idx <= w_win_idx;
                        r_pwrite  <= w_win_write;
                        r_paddr   <= w_win_addr;
                        r_pwdata  <= w_win_wdata;
                    end
                end
                APB_SETUP: begin
                    r_state   <= APB_ACCESS;
                    r_penable <= 1'b1;
                    r_wait    <= '0;
                end
                APB_ACCESS: begin
                    if (w_done) begin
                        r_ptr     <= w_ptr_adv;
                        r_penable <= 1'b0;
                        if (w_complete && w_win_any) begin
                            r_state   <= APB_SETUP;
                            r_gnt     <= w_win;
                            r_gnt_idx <= w_win_idx;
                            r_pwrite  <= w_win_write;
                            r_paddr   <= w_win_addr;
                            r_pwdata  <= w_win_wdata;
                        end else begin
                            r_state <= APB_IDLE;
                            r_psel  <= 1'b0;
                            r_gnt   <= '0;
                        end
                    end else if (r_wait != WAIT_MAX) begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                default: begin
                    r_state   <= APB_IDLE;
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                    r_gnt     <= '0;
                end
            endcase
        end
    end

    assign PSEL    = r_psel;
    assign PENABLE = r_penable;
    assign PWRITE  = r_pwrite;
    assign PADDR   = r_paddr;
    assign PWDATA  = r_pwdata;
    assign gnt_o   = r_gnt;
    assign done_o  = w_done ? r_gnt : '0;
    assign err_o   = w_timeout;
    assign rdata_o = PRDATA;

endmodule

// File: doc/apb_master_arbiter.md
Name: apb_master_arbiter

Overview:
- APB master controller that shares one APB bus between NUM_REQ local requesters.
- Sequences the APB IDLE -> SETUP -> ACCESS phases, including PREADY wait states, and returns completion and read data to the granted requester.
- Round-robin arbitration, back-to-back transfers without an idle cycle, and a wait-state timeout that aborts a transfer when PREADY stays low.
- Sits between the local requesters and APB slave peripherals such as the memory-backed APB slave.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_W, 32, PADDR width.
- DATA_W, 32, PWDATA/PRDATA width.
- TIMEOUT, 16, maximum ACCESS cycles with PREADY=0 before abort; 0 disables the timeout.

Ports:
- PCLK  in  1  clock. One clock domain; all logic on the rising edge.
- PRESET  in  1  reset, synchronous, active-high.
- req_i  in  NUM_REQ  per-requester transfer request; held high until that requester's done_o.
- write_i  in  NUM_REQ  per-requester direction; 1=write.
- addr_i  in  NUM_REQ*ADDR_W  packed per-requester address.
- wdata_i  in  NUM_REQ*DATA_W  packed per-requester write data.
- gnt_o  out  NUM_REQ  one-hot grant; high from SETUP through the last ACCESS cycle.
- done_o  out  NUM_REQ  one-hot completion; high for exactly one cycle.
- err_o  out  1  with done_o: 1 = timeout abort.
- rdata_o  out  DATA_W  combinational copy of PRDATA; valid only when done_o is high on a read with err_o=0.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PADDR  out  ADDR_W  APB address.
- PWDATA  out  DATA_W  APB write data.
- PRDATA  in  DATA_W  APB read data.
- PREADY  in  1  APB ready.

Behaviour:
- Reset values: PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, gnt_o=0, done_o=0, err_o=0. Round-robin pointer = requester 0 highest priority; wait counter = 0; state = IDLE.
- Reset mid-transfer: the bus is idle the cycle after the reset edge. No done_o is issued for the aborted transfer.

FSM states:
- IDLE: PSEL=0, PENABLE=0. If any req_i is high at an edge, the round-robin winner is granted. PADDR, PWRITE and PWDATA are latched from the winner's inputs and the next state is SETUP.
- SETUP: PSEL=1, PENABLE=0, lasting exactly one cycle. Always goes to ACCESS; the wait counter clears.
- ACCESS: PSEL=1, PENABLE=1.
  - PREADY=0: stay in ACCESS; the wait counter increments.
  - PREADY=1: done_o[grantee]=1 (combinational, this cycle) and err_o=0. The pointer moves to grantee+1 mod NUM_REQ.
    - If any other req_i is high: arbitrate now, latch the new winner's fields, go to SETUP. PSEL stays 1 and PENABLE drops to 0 (back-to-back).
    - Otherwise go to IDLE.
  - Timeout (TIMEOUT!=0, PREADY=0, wait counter == TIMEOUT-1): done_o[grantee]=1 with err_o=1, pointer advances, next state IDLE, PSEL/PENABLE drop.

Arbitration and timing rules:
- The grantee is masked from arbitration in its own done_o cycle. This allows it to drop req_i at that edge.
- Minimum transfer is 2 cycles (SETUP + 1 ACCESS). Each PREADY=0 cycle adds 1.
- Latency from req_i rising in IDLE to done_o with zero waits is 3 cycles.
- APB outputs are stable throughout SETUP and ACCESS. Changes on write_i/addr_i/wdata_i after grant are ignored.
- A requester deasserting req_i before grant is simply not served. Deassertion after grant has no effect; the transfer completes.
- Wait counter width is clog2(TIMEOUT+1); it saturates, it never wraps.
- PREADY is ignored in IDLE and SETUP.

Decomposition:
- Package apb_pkg: state enum (APB_IDLE, APB_SETUP, APB_ACCESS), default widths ADDR_W/DATA_W.
- Sub-module rr_arbiter (NUM_REQ): inputs req, mask, pointer; output one-hot winner. Purely combinational; the pointer register lives in the parent.
- The parent holds the FSM, the latched bus fields and the wait counter.

Test Plan:
- Single write, zero waits: req_i=01, addr0=0x10, wdata0=0xA5A5A5A5, PREADY=1 -> SETUP at cycle 1, ACCESS at cycle 2, done_o=01 at cycle 2, PSEL low at cycle 3.
- Read with 3 waits: req1 read addr 0x20, PREADY low 3 ACCESS cycles then PRDATA=0x1234 with PREADY=1 -> done_o=10 and rdata_o=0x1234 on the 4th ACCESS cycle, err_o=0.
- Contention and fairness: both requesters continuously requesting -> grants alternate 0,1,0,1 with back-to-back SETUP (PSEL never drops between transfers).
- Timeout: TIMEOUT=4, PREADY held 0 -> done_o with err_o=1 on the 4th ACCESS cycle, bus returns to IDLE, the next requester is served normally.
- Reset mid-ACCESS: assert PRESET during a waited transfer -> next cycle PSEL=0, PENABLE=0, gnt_o=0, no done_o; after reset, requester 0 has priority.
- Late deassert: req0 dropped in the SETUP cycle -> transfer still completes with the originally latched address and done_o=01.
